// File: rtl/rf_pkg.sv
`timescale 1ns/1ps
// rf_pkg: register-file writeback constants and port-select encoding shared
// by the writeback arbiter and its holding buffers.
package rf_pkg;

  localparam int unsigned RF_ADDR_W   = 5;
  localparam int unsigned RF_DATA_W   = 32;
  localparam int unsigned RF_ZERO_REG = 0;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_M = 1'b1
  } wb_sel_e;

  function automatic wb_sel_e other_port(input wb_sel_e s);
    return (s == SEL_A) ? SEL_M : SEL_A;
  endfunction

endpackage

// File: rtl/wb_hold_buf.sv
`timescale 1ns/1ps
// wb_hold_buf: 1-entry writeback holding buffer with valid/ready handshake.
// An accept with i_drop set completes the handshake but leaves the entry empty.
module wb_hold_buf #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_drop,
  input  logic              i_issue,
  output logic              o_ready,
  output logic              o_fill,
  output logic              o_v,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data
);

  logic              r_v;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              w_acc;

  // Ready while empty or while the entry leaves this cycle, so a port can
  // stream at full rate whenever it wins arbitration.
  assign o_ready = !r_v || i_issue;
  assign w_acc   = i_valid && o_ready;
  assign o_fill  = w_acc && !i_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v    <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_acc) begin
      r_v <= !i_drop;
      if (!i_drop) begin
        r_addr <= i_addr;
        r_data <= i_data;
      end
    end else if (i_issue) begin
      r_v <= 1'b0;
    end
  end

  assign o_v    = r_v;
  assign o_addr = r_addr;
  assign o_data = r_data;

endmodule

// File: rtl/rf_wb_arbiter.sv
`timescale 1ns/1ps
// rf_wb_arbiter: shares the single RF write port between ALU (A) and load (M).
// Define WB_FIXED_PRIO_EN to make M always win different-address contention.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] RdAddr,
  output logic [DATA_W-1:0] RdData,
  output logic              idle
);

  logic              w_a_v;
  logic              w_a_fill;
  logic [ADDR_W-1:0] w_a_addr;
  logic [DATA_W-1:0] w_a_data;
  logic              w_m_v;
  logic              w_m_fill;
  logic [ADDR_W-1:0] w_m_addr;
  logic [DATA_W-1:0] w_m_data;
  logic              w_a_drop;
  logic              w_m_drop;
  logic              w_issue_any;
  logic              w_issue_a;
  logic              w_issue_m;
  wb_sel_e           w_sel;

  logic              r_m_older;
  logic              r_regwrite;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_rd_data;

  assign w_a_drop = (a_addr == ADDR_W'(RF_ZERO_REG));
  assign w_m_drop = (m_addr == ADDR_W'(RF_ZERO_REG));

  wb_hold_buf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_buf_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (a_valid),
    .i_addr  (a_addr),
    .i_data  (a_data),
    .i_drop  (w_a_drop),
    .i_issue (w_issue_a),
    .o_ready (a_ready),
    .o_fill  (w_a_fill),
    .o_v     (w_a_v),
    .o_addr  (w_a_addr),
    .o_data  (w_a_data)
  );

  wb_hold_buf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_buf_m (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (m_valid),
    .i_addr  (m_addr),
    .i_data  (m_data),
    .i_drop  (w_m_drop),
    .i_issue (w_issue_m),
    .o_ready (m_ready),
    .o_fill  (w_m_fill),
    .o_v     (w_m_v),
    .o_addr  (w_m_addr),
    .o_data  (w_m_data)
  );

`ifdef WB_FIXED_PRIO_EN
  always_comb begin
    w_sel = SEL_A;
    if (w_a_v && w_m_v) begin
      if (w_a_addr == w_m_addr) begin
        w_sel = r_m_older ? SEL_M : SEL_A;
      end else begin
        w_sel = SEL_M;
      end
    end else if (w_m_v) begin
      w_sel = SEL_M;
    end
  end
`else
  wb_sel_e r_rr_ptr;
  logic    w_contend;

  always_comb begin
    w_sel     = SEL_A;
    w_contend = 1'b0;
    if (w_a_v && w_m_v) begin
      if (w_a_addr == w_m_addr) begin
        w_sel = r_m_older ? SEL_M : SEL_A;
      end else begin
        w_contend = 1'b1;
        w_sel     = r_rr_ptr;
      end
    end else if (w_m_v) begin
      w_sel = SEL_M;
    end
  end

  // Same-address ordering does not consume a round-robin turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= SEL_A;
    end else if (w_contend) begin
      r_rr_ptr <= other_port(w_sel);
    end
  end
`endif

  assign w_issue_any = w_a_v || w_m_v;
  assign w_issue_a   = w_issue_any && (w_sel == SEL_A);
  assign w_issue_m   = w_issue_any && (w_sel == SEL_M);

  // r_m_older means buf_M holds the earlier write: it becomes true when A
  // fills behind a waiting M, false when M fills behind a waiting A or when
  // both fill on the same edge (A counts as older then).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_older <= 1'b0;
    end else if (w_a_fill && w_m_fill) begin
      r_m_older <= 1'b0;
    end else if (w_a_fill && w_m_v && !w_issue_m) begin
      r_m_older <= 1'b1;
    end else if (w_m_fill && w_a_v && !w_issue_a) begin
      r_m_older <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regwrite <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_data  <= '0;
    end else begin
      r_regwrite <= w_issue_any;
      if (w_issue_any) begin
        r_rd_addr <= (w_sel == SEL_M) ? w_m_addr : w_a_addr;
        r_rd_data <= (w_sel == SEL_M) ? w_m_data : w_a_data;
      end
    end
  end

  assign RegWrite = r_regwrite;
  assign RdAddr   = r_rd_addr;
  assign RdData   = r_rd_data;
  assign idle     = !w_a_v && !w_m_v && !r_regwrite;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
`timescale 1ns/1ps
// tb_rf_wb_arbiter: scoreboard bench; accepted writes are queued and matched
// per destination register against RF writes, plus directed timing checks.
module tb_rf_wb_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk;
  logic          rst_n;
  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          m_valid;
  logic          m_ready;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          RegWrite;
  logic [AW-1:0] RdAddr;
  logic [DW-1:0] RdData;
  logic          idle;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t         sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  rf_wb_arbiter #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_addr   (m_addr),
    .m_data   (m_data),
    .RegWrite (RegWrite),
    .RdAddr   (RdAddr),
    .RdData   (RdData),
    .idle     (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: inputs and ready are stable at negedge, so an accept seen here is
  // the one taken at the following posedge. RF writes match the oldest queued
  // entry for the same register.
  always @(negedge clk) begin : monitor
    int idx;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (RegWrite) begin
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
          if (sb[i].addr == RdAddr) begin
            idx = i;
            break;
          end
        end
        check("sb_expected_write", {63'd0, idx >= 0}, 64'd1);
        if (idx >= 0) begin
          check("sb_data", RdData, sb[idx].data);
          sb.delete(idx);
        end
      end
      if (a_valid && a_ready && a_addr != '0) sb.push_back({a_addr, a_data});
      if (m_valid && m_ready && m_addr != '0) sb.push_back({m_addr, m_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    a_valid = 1'b0;
    m_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic next_wr(output logic [AW-1:0] addr, output logic [DW-1:0] data, output logic ok);
    ok   = 1'b0;
    addr = '0;
    data = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (RegWrite) begin
        ok   = 1'b1;
        addr = RdAddr;
        data = RdData;
        break;
      end
    end
  endtask

  task automatic expect_wr(input string tag, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    logic          ok;
    next_wr(ga, gd, ok);
    check({tag, "_seen"}, {63'd0, ok}, 64'd1);
    if (ok) begin
      check({tag, "_addr"}, ga, ea);
      check({tag, "_data"}, gd, ed);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (idle) break;
    end
    check({tag, "_idle"}, {63'd0, idle}, 64'd1);
    check({tag, "_sb_empty"}, sb.size(), 0);
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    logic          acc_a;
    logic          acc_m;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    logic          ok;

    rst_n   = 1'b0;
    a_valid = 1'b0;
    a_addr  = '0;
    a_data  = '0;
    m_valid = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_regwrite", RegWrite, 0);
    check("rst_rdaddr", RdAddr, 0);
    check("rst_rddata", RdData, 0);
    check("rst_a_ready", a_ready, 1);
    check("rst_m_ready", m_ready, 1);
    check("rst_idle", idle, 1);
    rst_n = 1'b1;
    tick();

    // single write latency and one-cycle pulse
    a_valid = 1'b1; a_addr = 5; a_data = 32'hDEADBEEF;
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    check("single_n_regwrite", RegWrite, 0);
    check("single_n_busy", idle, 0);
    tick();
    @(negedge clk);
    check("single_regwrite", RegWrite, 1);
    check("single_rdaddr", RdAddr, 5);
    check("single_rddata", RdData, 32'hDEADBEEF);
    tick();
    @(negedge clk);
    check("single_pulse_end", RegWrite, 0);
    check("single_idle", idle, 1);
    tick();

    // reset while buf_A holds a write
    a_valid = 1'b1; a_addr = 6; a_data = 32'h0000_1234;
    tick();
    a_valid = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_drop_regwrite", RegWrite, 0);
    end
    check("rst_drop_idle", idle, 1);
    tick();

    // R0 filter
    a_valid = 1'b1; a_addr = 0; a_data = 32'hFFFFFFFF;
    @(negedge clk);
    check("r0_a_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("r0_regwrite", RegWrite, 0);
      check("r0_idle", idle, 1);
    end
    tick();

    // same address: M first, then A one edge later
    m_valid = 1'b1; m_addr = 7; m_data = 32'h1;
    tick();
    m_valid = 1'b0;
    a_valid = 1'b1; a_addr = 7; a_data = 32'h2;
    tick();
    a_valid = 1'b0;
    expect_wr("ord_m_first", 7, 32'h1);
    expect_wr("ord_a_second", 7, 32'h2);
    drain("ord");

    // same address, simultaneous accept: A counts as older
    a_valid = 1'b1; a_addr = 9; a_data = 32'hA;
    m_valid = 1'b1; m_addr = 9; m_data = 32'hB;
    tick();
    a_valid = 1'b0;
    m_valid = 1'b0;
    expect_wr("sim_a_first", 9, 32'hA);
    expect_wr("sim_m_second", 9, 32'hB);
    drain("sim");

    // continuous contention on different addresses
    do_reset();
    a_valid = 1'b1; a_addr = 3; a_data = $urandom;
    m_valid = 1'b1; m_addr = 4; m_data = $urandom;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      acc_a = a_valid && a_ready;
      acc_m = m_valid && m_ready;
`ifdef WB_FIXED_PRIO_EN
      if (c >= 1) begin
        check("fix_a_ready", a_ready, 0);
        check("fix_m_ready", m_ready, 1);
      end
      if (c >= 2) begin
        check("fix_regwrite", RegWrite, 1);
        check("fix_rdaddr", RdAddr, 4);
      end
`else
      if (c >= 1) begin
        check("rr_a_ready", a_ready, (c % 2 == 1) ? 1 : 0);
        check("rr_m_ready", m_ready, (c % 2 == 0) ? 1 : 0);
      end
      if (c >= 2) begin
        check("rr_regwrite", RegWrite, 1);
        check("rr_rdaddr", RdAddr, (c % 2 == 0) ? 3 : 4);
      end
`endif
      tick();
      if (acc_a) a_data = $urandom;
      if (acc_m) m_data = $urandom;
    end
    a_valid = 1'b0;
    m_valid = 1'b0;
`ifdef WB_FIXED_PRIO_EN
    next_wr(ga, gd, ok);
    check("fix_last_m_seen", ok, 1);
    check("fix_last_m_addr", ga, 4);
    next_wr(ga, gd, ok);
    check("fix_a_after_m_seen", ok, 1);
    check("fix_a_after_m_addr", ga, 3);
`endif
    drain("contend");

    // random traffic over a few registers, including R0
    for (int c = 0; c < 300; c++) begin
      a_valid = 1'($urandom_range(0, 1));
      a_addr  = AW'($urandom_range(0, 3));
      a_data  = $urandom;
      m_valid = 1'($urandom_range(0, 1));
      m_addr  = AW'($urandom_range(0, 3));
      m_data  = $urandom;
      tick();
    end
    a_valid = 1'b0;
    m_valid = 1'b0;
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
